pslip_grant_arbiter: RTL

- Sequential grant arbiter for one output port of the pSLIP crossbar scheduler.
- Takes N per-input request priorities, picks the highest priority, and breaks ties with a round-robin pointer.
- Holds the grant until the input accepts it or a timeout expires.
- Advances the pointer only on an accepted grant (SLIP rule); the combinational max-priority selection is rebuilt internally per cycle.

---
 rtl/pslip_grant_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pslip_grant_arbiter.sv
// pslip_grant_arbiter: single-output-port grant arbiter for the pSLIP crossbar
// scheduler. Picks the highest request priority and breaks ties round-robin
// from ptr. The grant is held until the input accepts it or TMO cycles pass.
// The pointer moves only on an accepted grant.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_pri    per-input request priority, 0 = no request
//   accept     accept from the granted input (ignored when no grant is out)
//   gnt_valid  grant outstanding
//   gnt_idx    granted input index (held while gnt_valid=0)
//   gnt_pri    priority the grant was issued at (held while gnt_valid=0)
//   ptr        round-robin pointer
//   tmo_pulse  one-cycle pulse when a grant is withdrawn by timeout
module pslip_grant_arbiter #(
  parameter  int unsigned N   = 4,
  parameter  int unsigned P   = 16,
  parameter  int unsigned TMO = 4,
  localparam int unsigned IW  = $clog2(N),
  localparam int unsigned PW  = $clog2(P)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0][PW-1:0]  req_pri,
  input  logic                  accept,
  output logic                  gnt_valid,
  output logic [IW-1:0]         gnt_idx,
  output logic [PW-1:0]         gnt_pri,
  output logic [IW-1:0]         ptr,
  output logic                  tmo_pulse
);

  localparam int unsigned TW = $clog2(TMO) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [PW-1:0]   gnt_pri_q, gnt_pri_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            tmo_q, tmo_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [PW-1:0]   max_pri_c;
  logic [IW-1:0]   winner_c;
  logic            found_c;
  int unsigned     scan_c;

  // Highest requested priority this cycle.
  always_comb begin
    max_pri_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_pri[i] > max_pri_c) max_pri_c = req_pri[i];
    end
  end

  // First input at max priority, scanning from ptr with explicit wrap.
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    scan_c   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_c = 32'(ptr_q) + k;
      if (scan_c >= N) scan_c = scan_c - N;
      if (!found_c && (req_pri[IW'(scan_c)] == max_pri_c)) begin
        winner_c = IW'(scan_c);
        found_c  = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      gnt_pri_q   <= '0;
      ptr_q       <= '0;
      tmo_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_pri_q   <= gnt_pri_d;
      ptr_q       <= ptr_d;
      tmo_q       <= tmo_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_pri_d   = gnt_pri_q;
    ptr_d       = ptr_q;
    tmo_d       = 1'b0;
    timer_d     = timer_q;

    case (state_q)
      IDLE: begin
        if (max_pri_c != '0) begin
          gnt_idx_d   = winner_c;
          gnt_pri_d   = max_pri_c;
          gnt_valid_d = 1'b1;
          timer_d     = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Request changes are ignored here; only accept and the timer matter.
        if (accept) begin
          gnt_valid_d = 1'b0;
          ptr_d       = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);
          state_d     = IDLE;
        end else if (timer_q == TW'(TMO - 1)) begin
          gnt_valid_d = 1'b0;
          tmo_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_pri   = gnt_pri_q;
  assign ptr       = ptr_q;
  assign tmo_pulse = tmo_q;

endmodule
